alu_seq_ctrl: RTL

//  Multi-cycle sequencer in front of the shared combinational LC-3b ALU (ops ADD/AND/XOR/PASSA).

---
 rtl/alu_seq_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer in front of the shared LC-3b ALU.
//   Accepts one command over a valid/ready handshake, steps the external
//   combinational ALU (ADD/AND/XOR/PASSA) for one or more passes while
//   accumulating into an internal register, and returns RES plus NZP codes.
//   Adds NOT, SUB (two's-complement via XOR + ADD) and LSHF (repeated doubling).
// Ports:
//   CLK, RESET           clock (rising edge), synchronous active-high reset
//   CMD_VALID/READY      command handshake; CMD_READY high only in IDLE
//   CMD_OP/A/B           command opcode (0..7) and operands
//   ALU_A/B/SEL          drive the external ALU; 0/0/PASSA outside RUN
//   ALU_OUT              combinational ALU result for the current pass
//   RES_VALID/READY      result handshake; RES/RES_NZP held until taken
//   RES, RES_NZP         result and its {N,Z,P} condition codes
//   PASS_CNT             (only with ALU_SEQ_STATS_EN) saturating RUN-cycle count
// Configuration macro: ALU_SEQ_STATS_EN adds the PASS_CNT port and counter.
module alu_seq_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [2:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_A,
  input  logic [WIDTH-1:0] CMD_B,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [1:0]       ALU_SEL,
  input  logic [WIDTH-1:0] ALU_OUT,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES,
  output logic [2:0]       RES_NZP
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]      PASS_CNT
`endif
);

  // Pass counter must hold both the 3-pass SUB index and up to 2^SHAMT_W-1 shifts.
  localparam int unsigned PASS_W = (SHAMT_W > 2) ? SHAMT_W : 2;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_PASSA = 3'd3;
  localparam logic [2:0] OP_NOT   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_LSHF  = 3'd6;

  localparam logic [1:0] SEL_ADD   = 2'd0;
  localparam logic [1:0] SEL_XOR   = 2'd2;
  localparam logic [1:0] SEL_PASSA = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [PASS_W-1:0]  r_pass;
  logic [WIDTH-1:0]   r_res;
  logic [2:0]         r_nzp;
  logic               r_res_valid;
  logic               r_cmd_ready;

  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_alu_a;
  logic [WIDTH-1:0]   w_alu_b;
  logic [1:0]         w_alu_sel;
  logic               w_last;

  // {N,Z,P} of a result value.
  function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1])            nzp_of = 3'b100;
    else if (v == '0)          nzp_of = 3'b010;
    else                       nzp_of = 3'b001;
  endfunction

  assign w_shamt = r_b[SHAMT_W-1:0];

  // Pass schedule: ALU operands/select for the current pass and last-pass flag.
  always_comb begin
    w_alu_a   = '0;
    w_alu_b   = '0;
    w_alu_sel = SEL_PASSA;
    w_last    = 1'b1;
    if (r_state == S_RUN) begin
      case (r_op)
        OP_ADD, OP_AND, OP_XOR, OP_PASSA: begin
          w_alu_a   = r_a;
          w_alu_b   = r_b;
          w_alu_sel = r_op[1:0];
        end
        OP_NOT: begin
          w_alu_a   = r_a;
          w_alu_b   = '1;
          w_alu_sel = SEL_XOR;
        end
        OP_SUB: begin
          // A - B = A + (~B + 1), built up in the accumulator.
          case (r_pass)
            PASS_W'(0): begin
              w_alu_a   = r_b;
              w_alu_b   = '1;
              w_alu_sel = SEL_XOR;
              w_last    = 1'b0;
            end
            PASS_W'(1): begin
              w_alu_a   = r_acc;
              w_alu_b   = WIDTH'(1);
              w_alu_sel = SEL_ADD;
              w_last    = 1'b0;
            end
            default: begin
              w_alu_a   = r_a;
              w_alu_b   = r_acc;
              w_alu_sel = SEL_ADD;
            end
          endcase
        end
        OP_LSHF: begin
          if (w_shamt == '0) begin
            w_alu_a   = r_a;
            w_alu_sel = SEL_PASSA;
          end else begin
            // Each acc+acc pass doubles the value: one bit of left shift.
            w_alu_a   = r_acc;
            w_alu_b   = r_acc;
            w_alu_sel = SEL_ADD;
            w_last    = (r_pass == (PASS_W'(w_shamt) - PASS_W'(1)));
          end
        end
        default: begin
          w_alu_a   = r_a;
          w_alu_b   = r_b;
          w_alu_sel = SEL_PASSA;
        end
      endcase
    end
  end

  assign ALU_A     = w_alu_a;
  assign ALU_B     = w_alu_b;
  assign ALU_SEL   = w_alu_sel;
  assign CMD_READY = r_cmd_ready;
  assign RES_VALID = r_res_valid;
  assign RES       = r_res;
  assign RES_NZP   = r_nzp;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (CMD_VALID) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (RES_READY) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags registered from the next state so they track r_state exactly.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cmd_ready <= 1'b1;
      r_res_valid <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_res_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Command latch, accumulator, pass counter and result capture.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_pass <= '0;
      r_res  <= '0;
      r_nzp  <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (CMD_VALID) begin
            r_op   <= CMD_OP;
            r_a    <= CMD_A;
            r_b    <= CMD_B;
            r_acc  <= CMD_A;
            r_pass <= '0;
          end
        end
        S_RUN: begin
          r_acc  <= ALU_OUT;
          r_pass <= r_pass + PASS_W'(1);
          if (w_last) begin
            r_res <= ALU_OUT;
            r_nzp <= nzp_of(ALU_OUT);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] r_pass_cnt;

  // Saturating count of RUN cycles; cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RESET)                                       r_pass_cnt <= '0;
    else if (r_state == S_RUN && r_pass_cnt != '1)   r_pass_cnt <= r_pass_cnt + 16'd1;
  end

  assign PASS_CNT = r_pass_cnt;
`endif

endmodule
